keypad_encoder: RTL and testbench

Matrix-keypad front end for the pet feeder: scans a 4x4 active-low keypad, debounces presses and encodes them into the `keyboard_option`/`option_enable` and `keyboard_digit`/`digit_enable` interface consumed by `pet_feeder`. It is the transmitting end of that keyboard interface and sits between the physical keypad pins and `pet_feeder`.

---
 rtl/pet_feeder_pkg.sv | 50 +++++
 rtl/keypad_encoder_if.sv | 23 ++
 rtl/keypad_encoder_row_sync.sv | 27 ++
 rtl/keypad_encoder.sv | 176 +++++++++++++++++
 tb/tb_keypad_encoder.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pet_feeder_pkg.sv
// Shared pet feeder types: option codes, keypad FSM states and the keypad key map.
package pet_feeder_pkg;

  localparam int unsigned KP_LINES = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    POUR_FOOD = 3'b001,
    STOP_FOOD = 3'b010,
    INTERVAL  = 3'b011,
    RESET     = 3'b100
  } option_e;

  typedef enum logic [1:0] {
    KP_SCAN,
    KP_DEBOUNCE,
    KP_EMIT,
    KP_RELEASE
  } kp_state_e;

  typedef enum logic [1:0] {
    KEY_NONE,
    KEY_DIGIT,
    KEY_OPTION
  } key_class_e;

  typedef struct packed {
    key_class_e  cls;
    logic [3:0]  code;
  } key_entry_t;

  // Indexed by {row, col}: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D
  localparam key_entry_t KEY_MAP [16] = '{
    '{KEY_DIGIT,  4'd1}, '{KEY_DIGIT,  4'd2}, '{KEY_DIGIT, 4'd3}, '{KEY_OPTION, 4'(POUR_FOOD)},
    '{KEY_DIGIT,  4'd4}, '{KEY_DIGIT,  4'd5}, '{KEY_DIGIT, 4'd6}, '{KEY_OPTION, 4'(STOP_FOOD)},
    '{KEY_DIGIT,  4'd7}, '{KEY_DIGIT,  4'd8}, '{KEY_DIGIT, 4'd9}, '{KEY_OPTION, 4'(INTERVAL)},
    '{KEY_OPTION, 4'(IDLE)}, '{KEY_DIGIT, 4'd0}, '{KEY_NONE, 4'd0}, '{KEY_OPTION, 4'(RESET)}
  };

  // Index of the lowest-numbered row pulled low (0 when none is low).
  function automatic logic [1:0] lowest_low(input logic [KP_LINES-1:0] rows_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = KP_LINES - 1; i >= 0; i--) begin
      if (!rows_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_encoder_if.sv
// Keyboard bus from the keypad encoder (master) to pet_feeder (slave).
interface keypad_encoder_if;

  logic [2:0] keyboard_option;
  logic       option_enable;
  logic [3:0] keyboard_digit;
  logic       digit_enable;

  modport master (
    output keyboard_option,
    output option_enable,
    output keyboard_digit,
    output digit_enable
  );

  modport slave (
    input keyboard_option,
    input option_enable,
    input keyboard_digit,
    input digit_enable
  );

endinterface

// File: rtl/keypad_encoder_row_sync.sv
// Two-flop synchronizer for asynchronous active-low keypad rows; idles all-ones.
module row_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture; reset to released (all rows high).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 keypad scanner: column rotation, debounce of press/release, and encoding
// of accepted keys onto the pet_feeder keyboard bus.
module keypad_encoder
  import pet_feeder_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [KP_LINES-1:0] row_n,
  output logic [KP_LINES-1:0] col_n,
  keypad_encoder_if.master    kbd
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned MW = $clog2(DEBOUNCE + 1);

  kp_state_e     state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [MW-1:0] match_q, match_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    col_n_q, col_n_d;
  logic [2:0]    opt_q, opt_d;
  logic          opt_en_q, opt_en_d;
  logic [3:0]    dig_q, dig_d;
  logic          dig_en_q, dig_en_d;

  logic [KP_LINES-1:0] row_s;
  logic                sample_c;
  logic                any_low_c;
  logic [1:0]          low_row_c;
  logic [MW-1:0]       match_inc_c;
  logic                fire_c;
  key_entry_t          entry_c;

  row_sync #(.WIDTH(KP_LINES)) u_row_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (row_n),
    .q_o   (row_s)
  );

  assign sample_c    = (dwell_q == DW'(SCAN_DIV - 1));
  assign any_low_c   = ~&row_s;
  assign low_row_c   = lowest_low(row_s);
  assign match_inc_c = (match_q == MW'(DEBOUNCE)) ? match_q : match_q + MW'(1);
  assign dwell_d     = sample_c ? '0 : dwell_q + DW'(1);

  // Next-state, counters and encoded outputs.
  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    col_idx_d = col_idx_q;
    row_d     = row_q;
    opt_d     = opt_q;
    opt_en_d  = 1'b0;
    dig_d     = dig_q;
    dig_en_d  = 1'b0;
    fire_c    = 1'b0;
    entry_c   = KEY_MAP[0];

    case (state_q)
      KP_SCAN: begin
        if (sample_c) begin
          if (any_low_c) begin
            row_d = low_row_c;
            if (DEBOUNCE == 1) begin
              state_d = KP_EMIT;
              match_d = '0;
              fire_c  = 1'b1;
            end else begin
              state_d = KP_DEBOUNCE;
              match_d = MW'(1);
            end
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end
      KP_DEBOUNCE: begin
        if (sample_c) begin
          if (any_low_c && (low_row_c == row_q)) begin
            if (match_inc_c == MW'(DEBOUNCE)) begin
              state_d = KP_EMIT;
              match_d = '0;
              fire_c  = 1'b1;
            end else begin
              match_d = match_inc_c;
            end
          end else begin
            state_d   = KP_SCAN;
            match_d   = '0;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end
      KP_EMIT: begin
        state_d = KP_RELEASE;
        match_d = '0;
      end
      KP_RELEASE: begin
        if (sample_c) begin
          if (!any_low_c) begin
            if (match_inc_c == MW'(DEBOUNCE)) begin
              state_d   = KP_SCAN;
              match_d   = '0;
              col_idx_d = col_idx_q + 2'd1;
            end else begin
              match_d = match_inc_c;
            end
          end else begin
            match_d = '0;
          end
        end
      end
      default: begin
        state_d = KP_SCAN;
        match_d = '0;
      end
    endcase

    // Value and enable are registered together so data is valid with the pulse.
    if (fire_c) begin
      entry_c = KEY_MAP[{row_d, col_idx_q}];
      case (entry_c.cls)
        KEY_DIGIT: begin
          dig_d    = entry_c.code;
          dig_en_d = 1'b1;
        end
        KEY_OPTION: begin
          opt_d    = entry_c.code[2:0];
          opt_en_d = 1'b1;
        end
        default: ;
      endcase
    end

    col_n_d = ~(4'b0001 << col_idx_d);
  end

  // State, counter and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= KP_SCAN;
      dwell_q   <= '0;
      match_q   <= '0;
      col_idx_q <= 2'd0;
      row_q     <= 2'd0;
      col_n_q   <= 4'b1110;
      opt_q     <= 3'(IDLE);
      opt_en_q  <= 1'b0;
      dig_q     <= 4'd0;
      dig_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      match_q   <= match_d;
      col_idx_q <= col_idx_d;
      row_q     <= row_d;
      col_n_q   <= col_n_d;
      opt_q     <= opt_d;
      opt_en_q  <= opt_en_d;
      dig_q     <= dig_d;
      dig_en_q  <= dig_en_d;
    end
  end

  assign col_n               = col_n_q;
  assign kbd.keyboard_option = opt_q;
  assign kbd.option_enable   = opt_en_q;
  assign kbd.keyboard_digit  = dig_q;
  assign kbd.digit_enable    = dig_en_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: simulated keypad matrix, sample-level reference
// model checked every cycle, plus literal checks on pulse counts and values.
module tb_keypad_encoder;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEBOUNCE = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] pressed = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_opt_seen = 0;
  int n_dig_seen = 0;

  keypad_encoder_if kbd ();

  keypad_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clock (clock),
    .reset (reset),
    .row_n (row_n),
    .col_n (col_n),
    .kbd   (kbd)
  );

  always #5 clock = ~clock;

  // Physical matrix: a pressed key shorts its row to its column when driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) row_n[r] = ~|(pressed[r*4 +: 4] & ~col_n);
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one step per sample) ----------------
  string keys = "123A456B789C*0#D";
  int         m_dwell, m_col, m_phase, m_row, m_hits;
  int         m_opulse = 0, m_dpulse = 0;
  logic [3:0] m_s1, m_s2;
  int         exp_opt, exp_dig;
  bit         exp_oe, exp_de;

  function automatic logic [3:0] rows_for(input logic [15:0] keys_dn, input int col);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = !keys_dn[i*4 + col];
    return r;
  endfunction

  function automatic int first_low(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return -1;
  endfunction

  function automatic int exp_col_n();
    logic [3:0] e;
    e = 4'b1111;
    e[m_col] = 1'b0;
    return int'(e);
  endfunction

  task automatic model_reset();
    m_dwell = 0; m_col = 0; m_phase = 0; m_row = 0; m_hits = 0;
    m_s1 = 4'hF; m_s2 = 4'hF;
    exp_opt = 0; exp_dig = 0; exp_oe = 0; exp_de = 0;
  endtask

  task automatic accept();
    byte ch;
    m_phase = 2;
    m_hits  = 0;
    ch = keys[m_row*4 + m_col];
    if (ch >= "0" && ch <= "9") begin
      exp_dig = ch - "0"; exp_de = 1; m_dpulse++;
    end else if (ch != "#") begin
      case (ch)
        "A": exp_opt = 1;
        "B": exp_opt = 2;
        "C": exp_opt = 3;
        "D": exp_opt = 4;
        default: exp_opt = 0;
      endcase
      exp_oe = 1; m_opulse++;
    end
  endtask

  task automatic model_step();
    logic [3:0] pin;
    int low;
    pin = rows_for(pressed, m_col);
    exp_oe = 0;
    exp_de = 0;
    if (m_dwell == SCAN_DIV - 1) begin
      low = first_low(m_s2);
      case (m_phase)
        0: if (low >= 0) begin
             m_row = low; m_hits = 1;
             if (m_hits >= DEBOUNCE) accept(); else m_phase = 1;
           end else m_col = (m_col + 1) % 4;
        1: if (low == m_row) begin
             m_hits++;
             if (m_hits >= DEBOUNCE) accept();
           end else begin
             m_phase = 0; m_hits = 0; m_col = (m_col + 1) % 4;
           end
        default: if (low < 0) begin
             m_hits++;
             if (m_hits >= DEBOUNCE) begin m_phase = 0; m_hits = 0; m_col = (m_col + 1) % 4; end
           end else m_hits = 0;
      endcase
    end
    m_s2 = m_s1;
    m_s1 = pin;
    m_dwell = (m_dwell + 1) % SCAN_DIV;
  endtask

  // Compare process: DUT vs model every cycle, away from the active edge.
  always @(negedge clock) begin
    if (!reset) model_reset();
    check("col_n", int'(col_n), exp_col_n());
    check("keyboard_option", int'(kbd.keyboard_option), exp_opt);
    check("option_enable", int'(kbd.option_enable), int'(exp_oe));
    check("keyboard_digit", int'(kbd.keyboard_digit), exp_dig);
    check("digit_enable", int'(kbd.digit_enable), int'(exp_de));
    if (kbd.option_enable) n_opt_seen++;
    if (kbd.digit_enable)  n_dig_seen++;
    if (reset) model_step();
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic hold_key(input int idx, input int n_on, input int n_off);
    pressed[idx] = 1'b1;
    cycles(n_on);
    pressed[idx] = 1'b0;
    cycles(n_off);
  endtask

  task automatic wait_col(input logic [3:0] target);
    logic [3:0] prev;
    bit found;
    found = 0;
    prev = col_n;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clock);
      #2;
      if (col_n == target && prev != target) found = 1;
      prev = col_n;
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_col: timed out waiting for col_n=%b", target);
    end
  endtask

  // Press key idx from a column boundary for n whole dwells, then release.
  task automatic bounce(input int idx, input logic [3:0] col_target, input int n);
    wait_col(col_target);
    pressed[idx] = 1'b1;
    cycles(4 * n);
    pressed[idx] = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_col_n"}, int'(col_n), 4'b1110);
    check({tag, "_option"}, int'(kbd.keyboard_option), 0);
    check({tag, "_oe"}, int'(kbd.option_enable), 0);
    check({tag, "_digit"}, int'(kbd.keyboard_digit), 0);
    check({tag, "_de"}, int'(kbd.digit_enable), 0);
  endtask

  initial begin
    cycles(3);
    check_reset_values("por");
    reset = 1'b1;

    // Idle scan, all rows high
    cycles(20);
    check("idle_pulses", n_opt_seen + n_dig_seen, 0);

    // Key 7 held: one pulse, a second needs release plus fresh press
    hold_key(8, 40, 30);
    check("key7_pulses", n_dig_seen, 1);
    check("key7_digit", int'(kbd.keyboard_digit), 7);
    check("model_key7_pulses", m_dpulse, 1);
    hold_key(8, 40, 30);
    check("key7_again_pulses", n_dig_seen, 2);

    // A then C
    hold_key(3, 40, 30);
    check("keyA_option", int'(kbd.keyboard_option), 1);
    check("keyA_pulses", n_opt_seen, 1);
    hold_key(11, 40, 30);
    check("keyC_option", int'(kbd.keyboard_option), 3);
    check("keyC_pulses", n_opt_seen, 2);
    check("digit_held", int'(kbd.keyboard_digit), 7);
    check("model_opt_pulses", m_opulse, 2);

    // Bounce on key 5 (row1/col1)
    bounce(5, 4'b1101, 1);
    bounce(5, 4'b1101, 2);
    cycles(8);
    check("bounce_no_pulse", n_dig_seen, 2);
    bounce(5, 4'b1101, 3);
    cycles(30);
    check("key5_pulses", n_dig_seen, 3);
    check("key5_digit", int'(kbd.keyboard_digit), 5);

    // # held, then 0 in another column while # is held, then 0 alone
    pressed[14] = 1'b1;
    cycles(40);
    pressed[13] = 1'b1;
    cycles(40);
    pressed = '0;
    cycles(30);
    check("hash_no_pulse", n_dig_seen + n_opt_seen, 5);
    hold_key(13, 40, 30);
    check("key0_pulses", n_dig_seen, 4);
    check("key0_digit", int'(kbd.keyboard_digit), 0);

    // Reset while debouncing D
    wait_col(4'b0111);
    pressed[15] = 1'b1;
    cycles(5);
    reset = 1'b0;
    #1;
    check_reset_values("midrst");
    cycles(2);
    reset = 1'b1;
    cycles(20);
    check("keyD_not_yet", n_opt_seen, 2);
    cycles(20);
    check("keyD_pulses", n_opt_seen, 3);
    check("keyD_option", int'(kbd.keyboard_option), 4);
    pressed = '0;
    cycles(30);
    check("model_final_opt", m_opulse, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
